// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state encoding and parity helpers for the FIFO-fed UART transmitter
//
// Purpose: state enumeration, parity mode codes and a parity helper shared by the
//          transmitter top and (later) the receiver stage.
// Ports:   none (package).
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Even parity makes the total count of ones even, so the bit equals the XOR of the data.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        if (mode == PAR_ODD) begin
            return ~(^data);
        end
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - free-running bit-period counter with synchronous clear
//
// Purpose: counts 0..term_i and pulses bit_end_o on the cycle the count equals term_i,
//          then restarts from zero. Held at zero while clr_i is high.
// Ports:
//   clk       - clock, posedge
//   rst       - synchronous active-low reset
//   clr_i     - synchronous clear; suppresses bit_end_o
//   term_i    - terminal count (period length minus one)
//   bit_end_o - high on the final cycle of a period
//   count_o   - current count value
module uart_baud_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             bit_end_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign bit_end_o = !clr_i && (count_q == term_i);
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clr_i || bit_end_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a synchronous FIFO and serializes them as UART frames
//
// Purpose: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//          All outputs are registered and aligned with the state they belong to.
// Ports:
//   clk        - clock, posedge
//   rst        - synchronous active-low reset
//   enable     - permits new frames; sampled in IDLE and on the last stop cycle
//   fifo_empty - FIFO empty flag
//   fifo_dout  - FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    - one-cycle read strobe per byte
//   tx         - serial line, idle high
//   busy       - high whenever not IDLE
//   frame_done - one-cycle pulse on the final stop-bit cycle
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    // The counter is sized for the whole stop period so two stop bits time as one span.
    localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [CNT_W-1:0] BIT_TERM  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_TERM = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_PRE  = CNT_W'(CLKS_PER_BIT * STOP_BITS - 2);

    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        fifo_rd_q;
    logic        busy_q;
    logic        frame_done_q, frame_done_d;

    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_term;
    logic             bit_end;
    logic [CNT_W-1:0] cnt;

    // Counter only runs in the timed states so every timed state starts at count 0.
    assign cnt_clr  = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_WAIT);
    assign cnt_term = (state_q == ST_STOP) ? STOP_TERM : BIT_TERM;

    uart_baud_counter #(
        .CNT_W (CNT_W)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .term_i    (cnt_term),
        .bit_end_o (bit_end),
        .count_o   (cnt)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_d     = parity_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                shift_d  = fifo_dout;
                parity_d = parity_bit(fifo_dout, PARITY);
                state_d  = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = (enable && !fifo_empty) ? ST_POP : ST_IDLE;
                end else if (cnt == STOP_PRE) begin
                    // Registered pulse: set one cycle early so it lands on the final stop cycle.
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level is derived from the next state so the registered tx lines up with it.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            fifo_rd_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            fifo_rd_q    <= (state_d == ST_POP);
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo_rd    = fifo_rd_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    // Byte FIFO model feeding u0: data appears on dout the cycle after rd.
    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] dout0 = 8'h00;
    logic       empty0;
    logic       rd0, tx0, busy0, done0;
    assign empty0 = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd0) begin
            dout0  <= mem[rd_ptr[3:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty0), .fifo_dout(dout0),
        .fifo_rd(rd0), .tx(tx0), .busy(busy0), .frame_done(done0)
    );

    // Auxiliary instances (even parity, odd parity, two stop bits) each fed a constant 0xA5.
    logic [2:0] a_rd, a_tx, a_busy, a_done, a_empty;
    int a_push [3] = '{0, 0, 0};
    int a_pops [3] = '{0, 0, 0};
    assign a_empty[0] = (a_pops[0] >= a_push[0]);
    assign a_empty[1] = (a_pops[1] >= a_push[1]);
    assign a_empty[2] = (a_pops[2] >= a_push[2]);

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (a_rd[i]) a_pops[i] <= a_pops[i] + 1;
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(a_empty[0]), .fifo_dout(8'hA5),
        .fifo_rd(a_rd[0]), .tx(a_tx[0]), .busy(a_busy[0]), .frame_done(a_done[0])
    );
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(a_empty[1]), .fifo_dout(8'hA5),
        .fifo_rd(a_rd[1]), .tx(a_tx[1]), .busy(a_busy[1]), .frame_done(a_done[1])
    );
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(a_empty[2]), .fifo_dout(8'hA5),
        .fifo_rd(a_rd[2]), .tx(a_tx[2]), .busy(a_busy[2]), .frame_done(a_done[2])
    );

    logic [7:0] bb [3] = '{8'h00, 8'hFF, 8'h3C};

    // Frame length in cycles for CLKS_PER_BIT = 4.
    function automatic int flen(input int par, input int sb);
        return (9 + ((par != 0) ? 1 : 0) + sb) * 4;
    endfunction

    // Expected line level tt cycles after the first start-bit cycle.
    function automatic logic e_tx(input logic [7:0] d, input int tt, input int par);
        int b;
        if (tt < 0) return 1'b1;
        b = tt / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par != 0 && b == 9) return (par == 1) ? ^d : ~(^d);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k counts negedge samples after the edge that first sees enable & !empty (k=1 is POP).
    task automatic chk_frame(input string who, input int k, input logic [7:0] d, input int par,
                             input int sb, input logic t, input logic b, input logic r,
                             input logic dn);
        int tt;
        int len;
        tt  = k - 3;
        len = flen(par, sb);
        chk($sformatf("%s k%0d tx", who, k), 32'(t), 32'(e_tx(d, tt, par)));
        chk($sformatf("%s k%0d busy", who, k), 32'(b), 32'(k >= 1 && tt <= len - 1));
        chk($sformatf("%s k%0d rd", who, k), 32'(r), 32'(k == 1));
        chk($sformatf("%s k%0d done", who, k), 32'(dn), 32'(tt == len - 1));
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr++;
    endtask

    task automatic run_frame(input logic [7:0] d, input int drop_at);
        for (int k = 1; k <= flen(0, 1) + 4; k++) begin
            @(negedge clk);
            chk_frame("u0", k, d, 0, 1, tx0, busy0, rd0, done0);
            if (k == drop_at) enable = 1'b0;
        end
    endtask

    initial begin
        int p0;

        // Reset state
        rst = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx", 32'(tx0), 32'd1);
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst rd", 32'(rd0), 32'd0);
        chk("rst done", 32'(done0), 32'd0);
        chk("rst aux tx", 32'(a_tx), 32'h7);
        chk("rst aux busy", 32'(a_busy), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle tx", 32'(tx0), 32'd1);
        chk("idle busy", 32'(busy0), 32'd0);

        // Single 0xA5 frame on all four configurations
        push(8'hA5);
        a_push = '{1, 1, 1};
        enable = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            chk_frame("p0s1", k, 8'hA5, 0, 1, tx0, busy0, rd0, done0);
            chk_frame("even", k, 8'hA5, 1, 1, a_tx[0], a_busy[0], a_rd[0], a_done[0]);
            chk_frame("odd", k, 8'hA5, 2, 1, a_tx[1], a_busy[1], a_rd[1], a_done[1]);
            chk_frame("s2", k, 8'hA5, 0, 2, a_tx[2], a_busy[2], a_rd[2], a_done[2]);
        end
        chk("single pops", 32'(rd_ptr), 32'd1);
        chk("even pops", 32'(a_pops[0]), 32'd1);
        chk("odd pops", 32'(a_pops[1]), 32'd1);
        chk("s2 pops", 32'(a_pops[2]), 32'd1);

        // Empty FIFO with enable high: nothing happens
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("empty k%0d rd", k), 32'(rd0), 32'd0);
            chk($sformatf("empty k%0d tx", k), 32'(tx0), 32'd1);
            chk($sformatf("empty k%0d busy", k), 32'(busy0), 32'd0);
        end

        // Back-to-back frames: 40-cycle frames separated by POP and WAIT
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        for (int s = 0; s < 140; s++) begin
            int f;
            int r;
            int tt;
            @(negedge clk);
            f = s / 42;
            r = s % 42;
            tt = r - 2;
            if (f < 3) begin
                chk($sformatf("b2b s%0d tx", s), 32'(tx0), 32'(e_tx(bb[f], tt, 0)));
                chk($sformatf("b2b s%0d rd", s), 32'(rd0), 32'(r == 0));
                chk($sformatf("b2b s%0d busy", s), 32'(busy0), 32'd1);
                chk($sformatf("b2b s%0d done", s), 32'(done0), 32'(tt == 39));
            end else begin
                chk($sformatf("b2b s%0d tx", s), 32'(tx0), 32'd1);
                chk($sformatf("b2b s%0d rd", s), 32'(rd0), 32'd0);
                chk($sformatf("b2b s%0d busy", s), 32'(busy0), 32'd0);
            end
        end
        chk("b2b fifo empty", 32'(rd_ptr), 32'(wr_ptr));
        chk("b2b pops", 32'(rd_ptr), 32'd4);

        // Enable dropped during frame 1 of 2 queued bytes
        p0 = rd_ptr;
        push(8'h11);
        push(8'h22);
        run_frame(8'h11, 10);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("gate k%0d rd", k), 32'(rd0), 32'd0);
            chk($sformatf("gate k%0d busy", k), 32'(busy0), 32'd0);
        end
        chk("gate pops", 32'(rd_ptr - p0), 32'd1);
        enable = 1'b1;
        run_frame(8'h22, 0);
        chk("gate resume pops", 32'(rd_ptr - p0), 32'd2);

        // Reset in the middle of data bit 3 of 0x5A
        push(8'h5A);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk_frame("pre-rst", k, 8'h5A, 0, 1, tx0, busy0, rd0, done0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("midrst tx", 32'(tx0), 32'd1);
        chk("midrst busy", 32'(busy0), 32'd0);
        chk("midrst rd", 32'(rd0), 32'd0);
        chk("midrst done", 32'(done0), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk($sformatf("postrst k%0d tx", k), 32'(tx0), 32'd1);
            chk($sformatf("postrst k%0d rd", k), 32'(rd0), 32'd0);
            chk($sformatf("postrst k%0d busy", k), 32'(busy0), 32'd0);
        end
        chk("postrst fifo empty", 32'(rd_ptr), 32'(wr_ptr));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-deep synchronous byte FIFO.
- Pops one byte at a time through the FIFO's read/empty/d_out interface and serializes it as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between the FIFO and the board-level TX pin.
- Throttles itself purely through FIFO occupancy; no upstream handshake beyond read/empty.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal range >= 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- enable  input  1  permits starting new frames; sampled only at frame-start decision points.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  8  FIFO read data; valid the cycle after fifo_rd.
- fifo_rd  output  1  FIFO read strobe; one-cycle pulse per byte.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever state != IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset:
  - rst low at a posedge forces state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0.
  - Baud counter, bit counter and shift register are cleared.
  - All outputs are registered.
- States: IDLE, POP, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - If enable=1 and fifo_empty=0, go to POP.
  - Otherwise hold, tx=1.
- POP:
  - fifo_rd=1 for exactly this one cycle, tx=1; go to WAIT.
- WAIT:
  - Capture fifo_dout into the 8-bit shift register and compute the parity bit.
  - Go to START; tx=1.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1; bit end occurs at count CLKS_PER_BIT-1.
- DATA:
  - tx = shift[0]; at each bit end shift right and increment the bit counter.
  - After 8 bits go to PARITY if PARITY != 0, else to STOP.
- PARITY: tx = (^data) for even, ~(^data) for odd; duration CLKS_PER_BIT.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle, frame_done=1.
  - Next state is POP if enable=1 and fifo_empty=0 (back-to-back), else IDLE.
- Frame length: (1 + 8 + (PARITY?1:0) + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first tx=0 cycle.
- Back-to-back gap: exactly 2 extra idle-high cycles (POP, WAIT) between the last stop cycle and the next start bit.
- From IDLE, the first tx=0 occurs 3 cycles after the edge where IDLE sees enable & !fifo_empty.
- fifo_rd is never asserted when fifo_empty=1 at the decision edge, so at most one pop per frame.
- enable deasserted mid-frame: the current frame completes normally and no further pop occurs.
- fifo_empty toggling mid-frame is ignored; it is sampled only in IDLE and on the last stop cycle.
- Reset mid-frame: the line returns high on the reset edge. A byte already popped is discarded and not retransmitted.
- Counter widths:
  - Baud counter is $clog2(CLKS_PER_BIT*STOP_BITS) bits.
  - Bit counter is 3 bits and wraps 7->0 on DATA exit.
  - No arithmetic overflow is permitted.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - state encoding constants: ST_IDLE=0, ST_POP=1, ST_WAIT=2, ST_START=3, ST_DATA=4, ST_PARITY=5, ST_STOP=6;
  - parity codes PAR_NONE/PAR_EVEN/PAR_ODD.
- One sub-module, uart_baud_counter:
  - parameterized terminal count, synchronous clear, emits bit_end;
  - reused later by the RX stage.

Test Plan:
- Single byte, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1. FIFO holds 0xA5, enable=1. Required:
  - one fifo_rd pulse;
  - tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles;
  - frame_done pulses on cycle 40 of the frame;
  - busy drops the cycle after.
- Parity: the same byte 0xA5 with PARITY=1 gives a parity bit of 0; with PARITY=2 the parity bit is 1. Frame length is 44 cycles.
- Back-to-back: 3 bytes 0x00, 0xFF, 0x3C preloaded. Required:
  - exactly 3 fifo_rd pulses;
  - 2 idle-high cycles between frames;
  - the FIFO ends empty and the block returns to IDLE with tx=1.
- Empty and enable gating:
  - fifo_empty=1 with enable=1 gives no fifo_rd and tx=1 forever.
  - With 2 bytes queued and enable dropped during frame 1, frame 1 completes and no second pop occurs until enable returns.
- Reset mid-DATA: assert rst=0 at bit 3 of 0x5A. Required:
  - tx=1, busy=0, fifo_rd=0 on that edge;
  - after release with the FIFO empty, no frame starts.
- STOP_BITS=2, CLKS_PER_BIT=4: the stop period is 8 cycles high and frame_done is on its final cycle; total frame is 44 cycles with PARITY=0.
